ladybird_fetch_ctrl: RTL and testbench
======================================

Name: ladybird_fetch_ctrl

Overview:
Fetch sequencer in front of ladybird_ifu.
- Generates the sequential PC stream on the IFU pc/pc_valid/pc_ready handshake and tracks fetches that are still in flight.
- Buffers returned instructions in a small in-order queue for decode.
- Handles redirects (branch, trap) by flushing the queue and discarding stale IFU responses.
- The IFU response path cannot be back-pressured, so this block issues a fetch only when queue space is already reserved for its response.

Parameters:
RESET_VECTOR, 32'h8000_0000, PC loaded on reset.
QUEUE_DEPTH, 4, instruction queue entries; power of two, at least 2.
MAX_OUTSTANDING, 2, maximum accepted but unreturned IFU fetches; at most QUEUE_DEPTH.

Ports:
clk  in  1  clock.
nrst  in  1  reset; asynchronous, active-high (1 = reset asserted).
fetch_en  in  1  allow new fetches to issue.
redirect_valid  in  1  single-cycle redirect strobe.
redirect_pc  in  XLEN  new fetch PC; bits [1:0] are ignored and forced to 0.
pc  out  XLEN  fetch address to IFU.
pc_valid  out  1  fetch request to IFU.
pc_ready  in  1  IFU accepts the request.
inst  in  XLEN  IFU instruction word.
inst_valid  in  1  IFU response strobe; in order, no back-pressure.
inst_pc  in  XLEN  PC of the IFU response.
d_inst  out  XLEN  head-of-queue instruction.
d_pc  out  XLEN  head-of-queue PC.
d_valid  out  1  queue not empty.
d_ready  in  1  decode pops the head.
busy  out  1  outstanding count not zero, or drop count not zero.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_VECTOR; state = IDLE.
  - outstanding, drop_cnt and queue count all 0.
  - pc_valid = 0, d_valid = 0, busy = 0, pc = RESET_VECTOR, d_inst/d_pc = 0.
- State machine, two states:
  - IDLE to RUN when fetch_en = 1 and redirect_valid = 0.
  - RUN to IDLE when fetch_en = 0.
  - Responses still retire in IDLE.
- Issue, combinational:
  - pc = fetch_pc.
  - pc_valid = (state == RUN) & ~redirect_valid & (outstanding < MAX_OUTSTANDING) & (qcount + outstanding < QUEUE_DEPTH) & (drop_cnt == 0).
  - pc_valid may drop before pc_ready; the IFU samples only on pc_valid & pc_ready.
- Accept:
  - On pc_valid & pc_ready: fetch_pc += 4, wrapping modulo 2^XLEN; outstanding += 1.
- Response, on inst_valid:
  - outstanding -= 1 in all cases.
  - If drop_cnt != 0: drop_cnt -= 1 and the response is discarded.
  - Otherwise push {inst, inst_pc}.
  - Accept and response in the same cycle: outstanding is unchanged.
- Queue:
  - Show-ahead FIFO. d_valid = (qcount != 0); d_inst/d_pc show the head.
  - Pop on d_valid & d_ready.
  - Push and pop in the same cycle are legal at any fill level.
  - Push to a full queue cannot occur because of issue gating; the bench asserts this.
- Redirect (redirect_valid = 1, any state):
  - Next cycle: fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - Queue flushed: qcount = 0 and the head pointer reset.
  - A pop in the same cycle is ignored.
  - drop_cnt = outstanding_next, i.e. outstanding after this cycle's response decrement. No accept is possible this cycle.
  - A response arriving in the redirect cycle is discarded.
  - State is unchanged.
- Issue resumes only after drop_cnt reaches 0. Consequence: a new response is never confused with a stale one.
- busy = (outstanding != 0) | (drop_cnt != 0).
- Counter widths: $clog2(QUEUE_DEPTH+1) for qcount; $clog2(MAX_OUTSTANDING+1) for outstanding and drop_cnt.
- Reset asserted mid-operation clears all state immediately. In-flight IFU responses after reset release are not dropped; the IFU shares the same reset.

Decomposition:
- ladybird_config package: XLEN; the fetch state enum typedef fetch_state_t {FETCH_IDLE, FETCH_RUN}; the localparam for the default reset vector.
- One sub-module: ladybird_fetch_queue, a parameterised show-ahead FIFO with push, pop, flush, count and a {pc, inst} payload.

Test Plan:
- Reset, then fetch_en = 1 with pc_ready = 1 and a 1-cycle IFU -> pc issues 0x8000_0000, 0x8000_0004, ...; d_pc follows in the same order; outstanding never exceeds 2.
- d_ready = 0 held -> after 4 responses (qcount 4), pc_valid stays 0 (qcount + outstanding reaches 4); d_ready = 1 for one cycle -> exactly one further fetch issues.
- Two fetches outstanding, then redirect_valid with redirect_pc = 0x0000_1003 -> queue empty next cycle; the next 2 inst_valid are discarded; the next issued pc is 0x0000_1000.
- Redirect in the same cycle as inst_valid with 1 outstanding -> that response is discarded, drop_cnt = 0, issue resumes the next cycle at the redirect PC.
- fetch_pc = 0xFFFF_FFFC accepted -> next pc = 0x0000_0000.
- Assert nrst asynchronously mid-burst, between clock edges -> pc_valid, d_valid and busy go to 0 immediately; after release pc = 0x8000_0000 in IDLE.

Source files
------------

// File: rtl/ladybird_config_pkg.sv
// Shared configuration for the ladybird front end: data width, the fetch
// sequencer state encoding and the default reset vector.
package ladybird_config;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;

    typedef enum logic {
        FETCH_IDLE,
        FETCH_RUN
    } fetch_state_t;

endpackage

// File: rtl/ladybird_fetch_queue.sv
// Show-ahead instruction queue holding {pc, inst} pairs for decode.
// The head entry is visible combinationally; flush empties the queue in one cycle.
module ladybird_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_pc,
    input  logic [W-1:0]               push_inst,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_valid,
    output logic [W-1:0]               head_pc,
    output logic [W-1:0]               head_inst
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [2*W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_eff;

    // Pointer and occupancy update; flush wins over push and pop.
    always_comb begin
        pop_eff  = pop & (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)    wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_eff) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop_eff})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= {push_pc, push_inst};
    end

    // Head presentation, forced to zero while empty.
    always_comb begin
        head_valid = (count_q != '0);
        head_pc    = '0;
        head_inst  = '0;
        if (head_valid) {head_pc, head_inst} = mem_q[rd_ptr_q];
    end

    assign count = count_q;

endmodule

// File: rtl/ladybird_fetch_ctrl.sv
// Fetch sequencer: issues sequential PCs to the IFU only when queue space is
// reserved for the response, buffers responses for decode, and on redirect
// flushes the queue and discards responses still in flight.
module ladybird_fetch_ctrl
    import ladybird_config::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR    = DEFAULT_RESET_VECTOR,
    parameter int              QUEUE_DEPTH     = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    input  logic [XLEN-1:0] inst,
    input  logic            inst_valid,
    input  logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] d_inst,
    output logic [XLEN-1:0] d_pc,
    output logic            d_valid,
    input  logic            d_ready,
    output logic            busy
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH+1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING+1);

    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] qcount;
    logic [CNT_W:0]   fill;
    logic             accept;
    logic             push;
    logic             pop;

    // Issue gating: reserve a queue slot for every fetch before it is issued.
    always_comb begin
        fill     = {1'b0, qcount} + (CNT_W+1)'(outstanding_q);
        pc       = fetch_pc_q;
        pc_valid = (state_q == FETCH_RUN) & ~redirect_valid
                 & (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                 & (fill < (CNT_W+1)'(QUEUE_DEPTH))
                 & (drop_cnt_q == '0);
        accept   = pc_valid & pc_ready;
        push     = inst_valid & ~redirect_valid & (drop_cnt_q == '0);
        pop      = d_valid & d_ready & ~redirect_valid;
        busy     = (outstanding_q != '0) | (drop_cnt_q != '0);
    end

    // Next-state for run control, fetch PC and the in-flight/drop counters.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;

        case (state_q)
            FETCH_IDLE: if (fetch_en && !redirect_valid) state_d = FETCH_RUN;
            FETCH_RUN:  if (!fetch_en)                   state_d = FETCH_IDLE;
            default:                                     state_d = FETCH_IDLE;
        endcase

        case ({accept, inst_valid})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            // Everything still in flight after this cycle is stale.
            drop_cnt_d = outstanding_d;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (inst_valid && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - OUT_W'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q       <= FETCH_IDLE;
            fetch_pc_q    <= RESET_VECTOR;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    ladybird_fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .W     (XLEN)
    ) u_queue (
        .clk        (clk),
        .rst        (nrst),
        .push       (push),
        .push_pc    (inst_pc),
        .push_inst  (inst),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (qcount),
        .head_valid (d_valid),
        .head_pc    (d_pc),
        .head_inst  (d_inst)
    );

endmodule

// File: tb/tb_ladybird_fetch_ctrl.sv
// Bench for ladybird_fetch_ctrl: a queue-based model of the fetch rules,
// a small IFU responder, a per-cycle compare and directed scenarios.
module tb_ladybird_fetch_ctrl;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready = 1'b0;
    logic [31:0] inst = '0;
    logic        inst_valid = 1'b0;
    logic [31:0] inst_pc = '0;
    logic [31:0] d_inst;
    logic [31:0] d_pc;
    logic        d_valid;
    logic        d_ready = 1'b0;
    logic        busy;

    ladybird_fetch_ctrl dut (
        .clk            (clk),
        .nrst           (nrst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .d_inst         (d_inst),
        .d_pc           (d_pc),
        .d_valid        (d_valid),
        .d_ready        (d_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    bit          m_run;
    logic [31:0] m_fpc;
    int          m_out;
    int          m_drop;
    logic [31:0] mq_pc[$];
    logic [31:0] mq_inst[$];
    logic [31:0] ifu_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    bit          ifu_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run  = 1'b0;
        m_fpc  = 32'h8000_0000;
        m_out  = 0;
        m_drop = 0;
        mq_pc.delete();
        mq_inst.delete();
        ifu_q.delete();
    endfunction

    function automatic bit exp_pcv();
        return m_run && !redirect_valid && (m_out < 2) &&
               (mq_pc.size() + m_out < 4) && (m_drop == 0);
    endfunction

    // Model update at each active edge from the inputs of that cycle.
    always @(posedge clk) begin
        if (!nrst) begin
            bit acc, pop, push;
            acc = exp_pcv() && pc_ready;
            pop = (mq_pc.size() > 0) && d_ready;
            if (inst_valid) void'(ifu_q.pop_front());
            if (acc) begin
                acc_log.push_back(m_fpc);
                ifu_q.push_back(m_fpc);
            end
            m_out = m_out + int'(acc) - int'(inst_valid);
            if (redirect_valid) begin
                mq_pc.delete();
                mq_inst.delete();
                m_drop = m_out;
                m_fpc  = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                push = inst_valid && (m_drop == 0);
                if (inst_valid && m_drop > 0) m_drop--;
                if (pop) begin
                    pop_log.push_back(mq_pc[0]);
                    void'(mq_pc.pop_front());
                    void'(mq_inst.pop_front());
                end
                if (push) begin
                    n_cmp++;
                    if (mq_pc.size() >= 4) begin
                        n_bad++;
                        $display("FAIL push_full: push into full queue at %0t", $time);
                    end
                    mq_pc.push_back(inst_pc);
                    mq_inst.push_back(inst);
                end
                if (acc) m_fpc = m_fpc + 32'd4;
            end
            if (!m_run && fetch_en && !redirect_valid) m_run = 1'b1;
            else if (m_run && !fetch_en)               m_run = 1'b0;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (!nrst) begin
            check("pc", pc, m_fpc);
            check("pc_valid", {31'd0, pc_valid}, {31'd0, exp_pcv()});
            check("d_valid", {31'd0, d_valid}, {31'd0, mq_pc.size() > 0});
            check("d_pc", d_pc, (mq_pc.size() > 0) ? mq_pc[0] : 32'd0);
            check("d_inst", d_inst, (mq_inst.size() > 0) ? mq_inst[0] : 32'd0);
            check("busy", {31'd0, busy}, {31'd0, (m_out != 0) || (m_drop != 0)});
            check("max_outstanding", {31'd0, ifu_q.size() <= 2}, 32'd1);
        end
    end

    // Advance one clock and present the IFU response for the next cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (!ifu_hold && ifu_q.size() > 0) begin
            inst_valid = 1'b1;
            inst_pc    = ifu_q[0];
            inst       = ifu_q[0] ^ KEY;
        end else begin
            inst_valid = 1'b0;
            inst_pc    = '0;
            inst       = '0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int mark_a, mark_p, pre;
        model_reset();
        #12;
        @(negedge clk);
        #1;
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_pc_valid", {31'd0, pc_valid}, 32'd0);
        check("rst_d_valid", {31'd0, d_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_d_pc", d_pc, 32'd0);
        check("rst_d_inst", d_inst, 32'd0);
        nrst = 1'b0;

        // Sequential stream with a 1-cycle IFU.
        fetch_en = 1'b1; pc_ready = 1'b1; d_ready = 1'b1;
        run(12);
        check("seq_acc0", acc_log[0], 32'h8000_0000);
        check("seq_acc1", acc_log[1], 32'h8000_0004);
        check("seq_acc2", acc_log[2], 32'h8000_0008);
        check("seq_pop0", pop_log[0], 32'h8000_0000);
        check("seq_pop1", pop_log[1], 32'h8000_0004);
        $display("seq: %0d fetches accepted, %0d popped", acc_log.size(), pop_log.size());

        // Queue fills with decode stalled.
        d_ready = 1'b0;
        run(10);
        #1;
        check("full_pc_valid", {31'd0, pc_valid}, 32'd0);
        check("full_d_valid", {31'd0, d_valid}, 32'd1);
        d_ready = 1'b1;
        cycle();
        d_ready = 1'b0;
        pre = acc_log.size();
        run(6);
        check("one_more_fetch", acc_log.size() - pre, 32'd1);
        $display("full: single refill fetch at %08h", acc_log[pre]);

        // Redirect with two fetches outstanding.
        ifu_hold = 1'b1; d_ready = 1'b1;
        run(8);
        #1;
        check("pre_redir_pc_valid", {31'd0, pc_valid}, 32'd0);
        check("pre_redir_busy", {31'd0, busy}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1003;
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("redir_d_valid", {31'd0, d_valid}, 32'd0);
        check("redir_busy", {31'd0, busy}, 32'd1);
        check("redir_pc", pc, 32'h0000_1000);
        check("redir_pc_valid", {31'd0, pc_valid}, 32'd0);
        mark_a = acc_log.size(); mark_p = pop_log.size();
        ifu_hold = 1'b0;
        cycle();
        run(7);
        check("redir_first_acc", acc_log[mark_a], 32'h0000_1000);
        check("redir_first_pop", pop_log[mark_p], 32'h0000_1000);
        $display("redirect: resumed at %08h", acc_log[mark_a]);

        // Redirect coinciding with the only outstanding response.
        pc_ready = 1'b0;
        run(4);
        pc_ready = 1'b1;
        #1;
        check("r2_pre_pc_valid", {31'd0, pc_valid}, 32'd1);
        cycle();
        pc_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        #1;
        check("r2_resp_present", {31'd0, inst_valid}, 32'd1);
        cycle();
        redirect_valid = 1'b0;
        #1;
        check("r2_pc_valid", {31'd0, pc_valid}, 32'd1);
        check("r2_pc", pc, 32'h0000_2000);
        check("r2_busy", {31'd0, busy}, 32'd0);
        check("r2_d_valid", {31'd0, d_valid}, 32'd0);
        $display("redirect+resp: issue resumes at %08h", pc);

        // Address wrap.
        pc_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        cycle();
        redirect_valid = 1'b0;
        mark_a = acc_log.size();
        run(8);
        if (acc_log.size() < mark_a + 2) begin
            n_cmp++; n_bad++;
            $display("FAIL wrap_count: got %0d accepts want >= 2", acc_log.size() - mark_a);
        end else begin
            check("wrap_acc0", acc_log[mark_a], 32'hFFFF_FFFC);
            check("wrap_acc1", acc_log[mark_a+1], 32'h0000_0000);
            $display("wrap: %08h -> %08h", acc_log[mark_a], acc_log[mark_a+1]);
        end

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2;
        nrst = 1'b1;
        model_reset();
        inst_valid = 1'b0;
        fetch_en = 1'b0;
        #1;
        check("arst_pc_valid", {31'd0, pc_valid}, 32'd0);
        check("arst_d_valid", {31'd0, d_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_pc", pc, 32'h8000_0000);
        @(negedge clk);
        #2;
        nrst = 1'b0;
        run(2);
        #1;
        check("post_rst_pc", pc, 32'h8000_0000);
        check("post_rst_pc_valid", {31'd0, pc_valid}, 32'd0);
        fetch_en = 1'b1;
        mark_a = acc_log.size();
        run(4);
        check("post_rst_acc", acc_log[mark_a], 32'h8000_0000);
        $display("reset: restart at %08h", acc_log[mark_a]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
